// File: rtl/breakpoint_unit.sv
// rtl/breakpoint_unit.sv - hardware breakpoint table with registered active-low halt request
// Optional hit counter port/logic enabled by defining BREAKPOINT_HIT_COUNTER_EN.
module breakpoint_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_BP     = 4,
  localparam int IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_breakpointEnableN,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_fetch,
  input  logic                  i_wrEn,
  input  logic [IDX_W-1:0]      i_wrIdx,
  input  logic [ADDR_WIDTH-1:0] i_wrAddr,
  input  logic                  i_wrValid,
  input  logic                  i_resume,
  output logic                  o_breakpointHitN,
  output logic [IDX_W-1:0]      o_hitIdx,
  output logic [ADDR_WIDTH-1:0] o_hitPc
`ifdef BREAKPOINT_HIT_COUNTER_EN
  ,
  output logic [7:0]            o_hitCount
`endif
);

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    HIT   = 2'd1,
    SKIP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_BP-1:0]       valid_q;
  logic [ADDR_WIDTH-1:0]   addr_q [NUM_BP];
  logic [IDX_W-1:0]        hit_idx_q;
  logic [ADDR_WIDTH-1:0]   hit_pc_q;
  logic                    hit_n_q;
  logic                    match;
  logic [IDX_W-1:0]        match_idx;
  logic                    load_hit;

  // Priority search: lowest-index valid slot equal to the fetched PC.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (!match && valid_q[i] && (addr_q[i] == i_pc)) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    load_hit = 1'b0;
    if (i_breakpointEnableN) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (i_fetch && match) begin
            state_d  = HIT;
            load_hit = 1'b1;
          end
        end
        HIT: begin
          if (i_resume) state_d = SKIP;
        end
        SKIP: begin
          // Refetching the halted PC steps off the breakpoint instead of re-hitting.
          if (i_fetch) begin
            if (match && (i_pc != hit_pc_q)) begin
              state_d  = HIT;
              load_hit = 1'b1;
            end else begin
              state_d = ARMED;
            end
          end
        end
        default: state_d = ARMED;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q   <= ARMED;
      valid_q   <= '0;
      hit_idx_q <= '0;
      hit_pc_q  <= '0;
      hit_n_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hit_n_q <= (state_d != HIT);
      if (load_hit) begin
        hit_idx_q <= match_idx;
        hit_pc_q  <= i_pc;
      end
      for (int i = 0; i < NUM_BP; i++) begin
        if (i_wrEn && (i_wrIdx == IDX_W'(i))) valid_q[i] <= i_wrValid;
      end
    end
  end

  // Addresses are meaningless until their valid bit is set, so they carry no reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_BP; i++) begin
      if (i_wrEn && i_wrValid && (i_wrIdx == IDX_W'(i))) addr_q[i] <= i_wrAddr;
    end
  end

  assign o_breakpointHitN = hit_n_q;
  assign o_hitIdx         = hit_idx_q;
  assign o_hitPc          = hit_pc_q;

`ifdef BREAKPOINT_HIT_COUNTER_EN
  logic [7:0] hit_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      hit_cnt_q <= '0;
    end else if (load_hit && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_q <= hit_cnt_q + 8'd1;
    end
  end

  assign o_hitCount = hit_cnt_q;
`endif

endmodule

// File: tb/tb_breakpoint_unit.sv
// tb/tb_breakpoint_unit.sv - directed and randomized checks of breakpoint_unit against a behavioural model
module tb_breakpoint_unit;
  localparam int AW = 16;
  localparam int NB = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          resetn, en_n, fetch, wr_en, wr_valid, resume;
  logic [AW-1:0] pc, wr_addr;
  logic [IW-1:0] wr_idx;
  logic          hit_n;
  logic [IW-1:0] hit_idx;
  logic [AW-1:0] hit_pc;
  logic [7:0]    hit_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference state
  bit            m_valid [NB];
  logic [AW-1:0] m_addr  [NB];
  bit            m_halted, m_stepping;
  int            m_idx, m_cnt;
  logic [AW-1:0] m_pc;

  always #5 clk = ~clk;

  breakpoint_unit #(.ADDR_WIDTH(AW), .NUM_BP(NB)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_breakpointEnableN(en_n),
    .i_pc(pc), .i_fetch(fetch), .i_wrEn(wr_en), .i_wrIdx(wr_idx),
    .i_wrAddr(wr_addr), .i_wrValid(wr_valid), .i_resume(resume),
    .o_breakpointHitN(hit_n), .o_hitIdx(hit_idx), .o_hitPc(hit_pc)
`ifdef BREAKPOINT_HIT_COUNTER_EN
    , .o_hitCount(hit_count)
`endif
  );

`ifndef BREAKPOINT_HIT_COUNTER_EN
  assign hit_count = 8'd0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the table as it stood before the edge.
  task automatic model_edge();
    int first;
    first = -1;
    for (int i = NB - 1; i >= 0; i--)
      if (m_valid[i] && m_addr[i] == pc) first = i;
    if (!resetn) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_halted = 0; m_stepping = 0; m_idx = 0; m_pc = '0; m_cnt = 0;
    end else begin
      if (en_n) begin
        m_halted = 0; m_stepping = 0;
      end else if (m_halted) begin
        if (resume) begin m_halted = 0; m_stepping = 1; end
      end else if (fetch) begin
        if (first >= 0 && !(m_stepping && pc == m_pc)) begin
          m_halted = 1; m_idx = first; m_pc = pc;
          if (m_cnt < 255) m_cnt++;
        end
        m_stepping = 0;
      end
      if (wr_en && int'(wr_idx) < NB) begin
        m_valid[wr_idx] = wr_valid;
        if (wr_valid) m_addr[wr_idx] = wr_addr;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_hitN"}, hit_n, !m_halted);
    check_eq({tag, "_idx"}, hit_idx, m_idx);
    check_eq({tag, "_pc"}, hit_pc, m_pc);
`ifdef BREAKPOINT_HIT_COUNTER_EN
    check_eq({tag, "_cnt"}, hit_count, m_cnt);
`endif
  endtask

  task automatic step(input bit rn, input bit dis, input bit f, input logic [AW-1:0] p,
                      input bit we, input int wi, input logic [AW-1:0] wa, input bit wv,
                      input bit res);
    resetn = rn; en_n = dis; fetch = f; pc = p;
    wr_en = we; wr_idx = IW'(wi); wr_addr = wa; wr_valid = wv; resume = res;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [AW-1:0] p);
    step(1, 0, 1, p, 0, 0, 0, 0, 0);
  endtask

  task automatic do_resume();
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_write(input int wi, input logic [AW-1:0] wa, input bit wv);
    step(1, 0, 0, 0, 1, wi, wa, wv, 0);
  endtask

  initial begin
    foreach (m_addr[i]) m_addr[i] = '0;
    m_halted = 0; m_stepping = 0; m_idx = 0; m_pc = '0; m_cnt = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_hitN", hit_n, 1);
    check_eq("rst_idx", hit_idx, 0);
    check_eq("rst_pc", hit_pc, 0);
    check_eq("rst_cnt", hit_count, 0);

    do_write(0, 16'h0040, 1);
    do_fetch(16'h003E);
    check_eq("miss_3e", hit_n, 1);
    do_fetch(16'h0040);
    check_eq("hit40_n", hit_n, 0);
    check_eq("hit40_idx", hit_idx, 0);
    check_eq("hit40_pc", hit_pc, 16'h0040);
    do_fetch(16'h0100);
    check_eq("hold_n", hit_n, 0);
    check_eq("hold_pc", hit_pc, 16'h0040);

    do_write(1, 16'h0100, 1);
    do_write(3, 16'h0100, 1);
    check_eq("wr_in_hit_idx", hit_idx, 0);
    do_resume();
    check_eq("resume_n", hit_n, 1);
    do_fetch(16'h0042);
    do_fetch(16'h0100);
    check_eq("prio_n", hit_n, 0);
    check_eq("prio_idx", hit_idx, 1);

    do_resume();
    do_fetch(16'h0042);
    do_fetch(16'h0040);
    check_model("rehit40");
    do_resume();
    do_fetch(16'h0040);
    check_eq("stepoff_n", hit_n, 1);
    do_fetch(16'h0042);
    check_eq("miss_42", hit_n, 1);
    do_fetch(16'h0040);
    check_eq("hit_again_n", hit_n, 0);
`ifdef BREAKPOINT_HIT_COUNTER_EN
    check_eq("cnt_after", hit_count, 4);
`endif

    do_resume();
    do_fetch(16'h0042);
    step(1, 0, 1, 16'h0200, 1, 2, 16'h0200, 1, 0);
    check_eq("same_cycle_wr", hit_n, 1);
    do_fetch(16'h0200);
    check_eq("new_entry_hit", hit_n, 0);
    check_eq("new_entry_idx", hit_idx, 2);

    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("disable_rel", hit_n, 1);
    step(1, 1, 1, 16'h0040, 0, 0, 0, 0, 0);
    check_eq("disabled_fetch", hit_n, 1);
    do_write(0, 16'h0000, 0);
    do_fetch(16'h0040);
    check_eq("cleared_slot", hit_n, 1);
    check_model("after_clear");

    do_write(0, 16'h0040, 1);
    for (int k = 0; k < 260; k++) begin
      do_fetch(16'h0040);
      do_resume();
      do_fetch(16'h0042);
    end
    check_model("sat");
`ifdef BREAKPOINT_HIT_COUNTER_EN
    check_eq("sat_cnt", hit_count, 255);
`endif
    do_fetch(16'h0040);
    check_eq("pre_rst_hitN", hit_n, 0);
    step(0, 0, 1, 16'h0040, 0, 0, 0, 0, 0);
    check_eq("midhit_rst_n", hit_n, 1);
    check_eq("midhit_rst_cnt", hit_count, 0);
    do_fetch(16'h0100);
    do_fetch(16'h0040);
    check_eq("table_empty", hit_n, 1);

    for (int k = 0; k < 3000; k++) begin
      logic [AW-1:0] pool [4];
      logic [AW-1:0] p, wa;
      pool[0] = 16'h0040; pool[1] = 16'h0042; pool[2] = 16'h0100; pool[3] = 16'h0200;
      p  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : pool[$urandom_range(0, 3)];
      wa = pool[$urandom_range(0, 3)];
      step($urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, p,
           $urandom_range(0, 5) == 0, int'($urandom_range(0, NB - 1)), wa,
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
